mult_sched: RTL and testbench
=============================

Name: mult_sched

Overview:
- Sequencer and arbiter that shares one radix-2 Booth shift-add multiplier datapath (A, Q, q_menos1 and M registers, adder/subtractor) between two requesters.
- Picks a requester round-robin and steers the operand mux to it.
- Generates the datapath control strobes (Carga_QM, Reset_A, Carga_A, Resta, Desplaza_AQ, Fin) for an N-iteration Booth multiply.
- Returns a one-cycle done pulse to the winning requester.
- Sits between the requester interfaces and the existing multiplier datapath; replaces the fixed-length control unit.

Parameters:
- N, 3, operand width = number of Booth iterations; legal range 2..32.
- CW, $clog2(N), iteration counter width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  2  request per requester; held high until the matching done pulse
- q0  in  1  LSB of datapath Q register
- q_menos1  in  1  datapath q(-1) bit
- gnt  out  2  one-hot grant; constant for a whole operation
- Sel  out  1  operand mux select: 0 = requester 0, 1 = requester 1
- busy  out  1  high in every state except IDLE
- done  out  2  one-hot, one-cycle completion pulse to the granted requester
- Carga_QM  out  1  load multiplier into Q, multiplicand into M, clear q(-1)
- Reset_A  out  1  clear A
- Carga_A  out  1  load adder/subtractor result into A
- Resta  out  1  adder/subtractor performs A−M (else A+M)
- Desplaza_AQ  out  1  arithmetic right shift of A,Q,q(-1)
- Fin  out  1  operation complete, one cycle, coincident with done

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and the counter clears.
  - gnt=00, Sel=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - All strobes, busy and done are 0.
  - A reset mid-operation aborts the operation with no done pulse.
- States: IDLE, LOAD, EVAL, SHIFT, DONE.
- IDLE:
  - If req≠00, register gnt and Sel (the arbitration result) and go to LOAD.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only one request active: grant it.
  - Both active: grant the requester that is not last.
- LOAD (1 cycle): Carga_QM=1, Reset_A=1, counter cleared; go to EVAL.
- EVAL (1 cycle):
  - Carga_A = q0 XOR q_menos1.
  - Resta = q0 AND NOT q_menos1.
  - These are combinational (Mealy) on q0/q_menos1; both are 0 in every other state.
  - Go to SHIFT.
- SHIFT (1 cycle):
  - Desplaza_AQ=1.
  - If counter==N-1, go to DONE; else increment the counter and go to EVAL.
- DONE (1 cycle):
  - Fin=1 and done[Sel]=1.
  - last ← Sel.
  - gnt ← 00 on exit; go to IDLE.
- All other outputs are Moore, decoded from state; busy = (state≠IDLE).
- Latency: request sampled in IDLE at edge k gives LOAD in cycle k+1 and DONE in cycle k+2+2N (k+8 for N=3). Back-to-back operations cost 3+2N cycles, including one IDLE cycle.
- Request dropped mid-operation: the operation still completes and done still pulses. The requester must ignore it.
- Request raised during DONE: not considered until the following IDLE cycle.
- Both requests held continuously: grants strictly alternate 0,1,0,1…
- The counter never wraps; it is cleared in LOAD.
- Illegal state encodings recover to IDLE with outputs 0.

Test Plan:
- Reset check: assert reset=0 mid-SHIFT with req=01 → outputs are 0 within the same cycle, state is IDLE, and no done[0] pulse is ever seen.
- Single request, N=3: req=01 at edge k; bench drives (q0,q_menos1)=10, 11, 01 in the three EVAL cycles (multiplier 011). Expected:
  - gnt=01, Sel=0.
  - Carga_QM=Reset_A=1 at k+1.
  - EVAL1: Carga_A=1, Resta=1. EVAL2: Carga_A=0, Resta=0. EVAL3: Carga_A=1, Resta=0.
  - Desplaza_AQ=1 at k+3, k+5, k+7.
  - done=01 and Fin=1 at k+8 only.
- Contention: req=11 held from reset → grant order 0,1,0,1. done pulses at k+8, k+17, k+26, k+35, alternating 01, 10, 01, 10.
- Request withdrawal: req=10, then drop req[1] at k+4 → sequence continues; done=10 at k+8; next IDLE sees no grant.
- Parameter sweep N=8: single request → exactly 8 Desplaza_AQ pulses, done at k+18, busy high k+1..k+18.
- Late request: req[0] rises during DONE of a requester-1 operation → not granted until the IDLE cycle after DONE; LOAD follows on the next cycle.

Source files
------------

// File: rtl/mult_sched.sv
// mult_sched: round-robin arbiter and sequencer for a shared radix-2 Booth
// shift-add multiplier datapath (A, Q, q(-1), M registers plus adder/subtractor).
//
// The FSM walks LOAD -> (EVAL -> SHIFT) x N -> DONE for each operation. It
// drives the datapath strobes and returns a one-cycle done pulse to the
// requester that was granted.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   req[1:0]    in   per-requester request, held until the matching done
//   q0          in   LSB of datapath Q
//   q_menos1    in   datapath q(-1)
//   gnt[1:0]    out  one-hot grant, stable for the whole operation
//   Sel         out  operand mux select (0 = requester 0, 1 = requester 1)
//   busy        out  high in every legal state except IDLE
//   done[1:0]   out  one-cycle completion pulse to the granted requester
//   Carga_QM    out  load Q/M, clear q(-1)
//   Reset_A     out  clear A
//   Carga_A     out  load adder/subtractor result into A
//   Resta       out  adder/subtractor computes A-M (else A+M)
//   Desplaza_AQ out  arithmetic right shift of A,Q,q(-1)
//   Fin         out  operation complete, coincident with done
module mult_sched #(
  parameter int N  = 3,
  parameter int CW = $clog2(N)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       q0,
  input  logic       q_menos1,
  output logic [1:0] gnt,
  output logic       Sel,
  output logic       busy,
  output logic [1:0] done,
  output logic       Carga_QM,
  output logic       Reset_A,
  output logic       Carga_A,
  output logic       Resta,
  output logic       Desplaza_AQ,
  output logic       Fin
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EVAL  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_gnt;
  logic          r_sel;
  logic          r_last;
  logic          w_pick1;

  // Requester 1 wins when it is the only one asking, or on a tie when
  // requester 0 was served last.
  assign w_pick1 = req[1] & (~req[0] | ~r_last);

  assign gnt = r_gnt;
  assign Sel = r_sel;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Grant, mux select, round-robin pointer and iteration counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt  <= 2'b00;
      r_sel  <= 1'b0;
      r_last <= 1'b1;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req != 2'b00) begin
            r_gnt <= w_pick1 ? 2'b10 : 2'b01;
            r_sel <= w_pick1;
          end
        end
        S_LOAD: begin
          r_cnt <= '0;
        end
        S_EVAL: begin
          r_cnt <= r_cnt;
        end
        S_SHIFT: begin
          // Hold at N-1 on the final shift so the counter never wraps.
          if (r_cnt != C_LAST) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_last <= r_sel;
          r_gnt  <= 2'b00;
        end
        default: begin
          r_gnt <= 2'b00;
          r_sel <= 1'b0;
        end
      endcase
    end
  end

  // Next-state and strobe decode; Carga_A/Resta are Mealy on the Booth pair
  // in EVAL, everything else is Moore.
  always_comb begin
    w_next      = r_state;
    busy        = 1'b0;
    done        = 2'b00;
    Carga_QM    = 1'b0;
    Reset_A     = 1'b0;
    Carga_A     = 1'b0;
    Resta       = 1'b0;
    Desplaza_AQ = 1'b0;
    Fin         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req != 2'b00) begin
          w_next = S_LOAD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LOAD: begin
        busy     = 1'b1;
        Carga_QM = 1'b1;
        Reset_A  = 1'b1;
        w_next   = S_EVAL;
      end
      S_EVAL: begin
        busy    = 1'b1;
        Carga_A = q0 ^ q_menos1;
        Resta   = q0 & ~q_menos1;
        w_next  = S_SHIFT;
      end
      S_SHIFT: begin
        busy        = 1'b1;
        Desplaza_AQ = 1'b1;
        if (r_cnt == C_LAST) begin
          w_next = S_DONE;
        end else begin
          w_next = S_EVAL;
        end
      end
      S_DONE: begin
        busy   = 1'b1;
        Fin    = 1'b1;
        done   = r_sel ? 2'b10 : 2'b01;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_sched.sv
// Directed testbench for mult_sched. Expected done pulses are queued when a
// request is driven and popped when the DUT reports completion.
module tb_mult_sched;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic       q0;
  logic       q_menos1;
  logic [1:0] gnt;
  logic       Sel;
  logic       busy;
  logic [1:0] done;
  logic       Carga_QM, Reset_A, Carga_A, Resta, Desplaza_AQ, Fin;

  logic [1:0] req8;
  logic [1:0] gnt8;
  logic       Sel8, busy8;
  logic [1:0] done8;
  logic       cqm8, ra8, ca8, rs8, dz8, fin8;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  logic [1:0] sb_q[$];

  mult_sched #(.N(3)) dut (
    .clk(clk), .reset(reset), .req(req), .q0(q0), .q_menos1(q_menos1),
    .gnt(gnt), .Sel(Sel), .busy(busy), .done(done),
    .Carga_QM(Carga_QM), .Reset_A(Reset_A), .Carga_A(Carga_A), .Resta(Resta),
    .Desplaza_AQ(Desplaza_AQ), .Fin(Fin)
  );

  mult_sched #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .req(req8), .q0(1'b0), .q_menos1(1'b0),
    .gnt(gnt8), .Sel(Sel8), .busy(busy8), .done(done8),
    .Carga_QM(cqm8), .Reset_A(ra8), .Carga_A(ca8), .Resta(rs8),
    .Desplaza_AQ(dz8), .Fin(fin8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and score any done pulse from the N=3 instance.
  task automatic cyc();
    logic [1:0] e;
    @(posedge clk);
    #2;
    if (done !== 2'b00) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        chk("done_unexpected", {30'd0, done}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("done_sb", {30'd0, done}, {30'd0, e});
      end
      chk("fin_with_done", {31'd0, Fin}, 32'd1);
    end
  endtask

  initial begin
    int seen_before;
    int shifts;
    logic [1:0] exp_d;
    reset = 1'b0; req = 2'b00; req8 = 2'b00; q0 = 1'b0; q_menos1 = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_done", {30'd0, done}, 32'd0);
    reset = 1'b1;
    cyc();

    // Single request, multiplier 011.
    req = 2'b01; sb_q.push_back(2'b01);
    cyc();                                   // k+1 LOAD
    chk("s_gnt", {30'd0, gnt}, 32'd1);
    chk("s_sel", {31'd0, Sel}, 32'd0);
    chk("s_cqm", {31'd0, Carga_QM}, 32'd1);
    chk("s_ra", {31'd0, Reset_A}, 32'd1);
    chk("s_busy", {31'd0, busy}, 32'd1);
    cyc(); q0 = 1'b1; q_menos1 = 1'b0; #1;   // k+2 EVAL1
    chk("e1_ca", {31'd0, Carga_A}, 32'd1);
    chk("e1_rs", {31'd0, Resta}, 32'd1);
    cyc();                                   // k+3 SHIFT
    chk("sh1_dz", {31'd0, Desplaza_AQ}, 32'd1);
    chk("sh1_ca_off", {31'd0, Carga_A}, 32'd0);
    cyc(); q0 = 1'b1; q_menos1 = 1'b1; #1;   // k+4 EVAL2
    chk("e2_ca", {31'd0, Carga_A}, 32'd0);
    chk("e2_rs", {31'd0, Resta}, 32'd0);
    chk("e2_dz", {31'd0, Desplaza_AQ}, 32'd0);
    cyc();                                   // k+5
    chk("sh2_dz", {31'd0, Desplaza_AQ}, 32'd1);
    cyc(); q0 = 1'b0; q_menos1 = 1'b1; #1;   // k+6 EVAL3
    chk("e3_ca", {31'd0, Carga_A}, 32'd1);
    chk("e3_rs", {31'd0, Resta}, 32'd0);
    cyc();                                   // k+7
    chk("sh3_dz", {31'd0, Desplaza_AQ}, 32'd1);
    chk("sh3_done0", {30'd0, done}, 32'd0);
    cyc();                                   // k+8 DONE
    chk("s_done_k8", {30'd0, done}, 32'd1);
    chk("s_fin_k8", {31'd0, Fin}, 32'd1);
    req = 2'b00; q0 = 1'b0; q_menos1 = 1'b0;
    cyc();                                   // k+9 IDLE
    chk("s_idle_busy", {31'd0, busy}, 32'd0);
    chk("s_idle_gnt", {30'd0, gnt}, 32'd0);
    chk("s_sb_empty", sb_q.size(), 32'd0);

    // Reset asserted mid-SHIFT aborts without a done pulse.
    req = 2'b01;
    cyc(); cyc(); cyc();                     // k+3 SHIFT
    chk("ab_in_shift", {31'd0, Desplaza_AQ}, 32'd1);
    seen_before = done_seen;
    reset = 1'b0; #1;
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_dz", {31'd0, Desplaza_AQ}, 32'd0);
    chk("ab_gnt", {30'd0, gnt}, 32'd0);
    chk("ab_done", {30'd0, done}, 32'd0);
    req = 2'b00;
    cyc(); cyc();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) cyc();
    chk("ab_no_done", done_seen, seen_before);

    // Contention: both held, grants alternate 0,1,0,1 starting from requester 0.
    req = 2'b11;
    for (int i = 0; i < 4; i++) sb_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
    for (int i = 1; i <= 35; i++) begin
      cyc();
      if (i == 8 || i == 17 || i == 26 || i == 35) begin
        exp_d = (((i - 8) / 9) % 2 == 0) ? 2'b01 : 2'b10;
        chk("ct_done", {30'd0, done}, {30'd0, exp_d});
      end else begin
        chk("ct_nodone", {30'd0, done}, 32'd0);
      end
      if (i == 1)  chk("ct_gnt1", {30'd0, gnt}, 32'd1);
      if (i == 10) chk("ct_gnt2", {30'd0, gnt}, 32'd2);
      if (i == 9)  chk("ct_idle_gnt", {30'd0, gnt}, 32'd0);
    end
    req = 2'b00;
    cyc();

    // Withdrawal: requester 1 drops its request at k+4.
    req = 2'b10; sb_q.push_back(2'b10);
    cyc();
    chk("wd_gnt", {30'd0, gnt}, 32'd2);
    chk("wd_sel", {31'd0, Sel}, 32'd1);
    cyc(); cyc(); cyc();                     // k+4
    req = 2'b00;
    cyc(); cyc(); cyc(); cyc();              // k+8
    chk("wd_done", {30'd0, done}, 32'd2);
    cyc();
    chk("wd_idle_gnt", {30'd0, gnt}, 32'd0);
    cyc();
    chk("wd_no_regrant", {30'd0, gnt}, 32'd0);
    chk("wd_no_busy", {31'd0, busy}, 32'd0);

    // Late request raised during requester 1's DONE.
    req = 2'b10; sb_q.push_back(2'b10);
    for (int i = 0; i < 8; i++) cyc();       // k+8 DONE
    chk("lt_done1", {30'd0, done}, 32'd2);
    req = 2'b01; sb_q.push_back(2'b01);
    cyc();                                   // IDLE
    chk("lt_idle_busy", {31'd0, busy}, 32'd0);
    chk("lt_idle_gnt", {30'd0, gnt}, 32'd0);
    cyc();                                   // LOAD
    chk("lt_load", {31'd0, Carga_QM}, 32'd1);
    chk("lt_gnt", {30'd0, gnt}, 32'd1);
    for (int i = 0; i < 7; i++) cyc();
    chk("lt_done0", {30'd0, done}, 32'd1);
    req = 2'b00;
    cyc();
    chk("sb_empty_end", sb_q.size(), 32'd0);

    // N=8 sweep on the second instance.
    req8 = 2'b01;
    shifts = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (dz8 === 1'b1) shifts++;
      chk("n8_busy", {31'd0, busy8}, (i <= 18) ? 32'd1 : 32'd0);
      chk("n8_done", {30'd0, done8}, (i == 18) ? 32'd1 : 32'd0);
      if (i == 18) req8 = 2'b00;
    end
    chk("n8_shifts", shifts, 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
